// File: rtl/rgb_write_scheduler_if.sv
// rgb_write_scheduler_if: frame control, pixel handshake, converter
// datapath and SRAM write port of the YUV->RGB write scheduler.
interface rgb_write_scheduler_if;
    logic               start;
    logic               busy;
    logic               done;
    logic               yuv_valid;
    logic               yuv_ready;
    logic [7:0]         Y_in;
    logic [7:0]         U_in;
    logic [7:0]         V_in;
    logic               conv_enable;
    logic [31:0]        conv_Y;
    logic [31:0]        conv_U;
    logic [31:0]        conv_V;
    logic signed [31:0] conv_R;
    logic signed [31:0] conv_G;
    logic signed [31:0] conv_B;
    logic [17:0]        SRAM_address;
    logic [15:0]        SRAM_write_data;
    logic               SRAM_we_n;

    modport slave (
        input  start, yuv_valid, Y_in, U_in, V_in,
        input  conv_R, conv_G, conv_B,
        output busy, done, yuv_ready, conv_enable,
        output conv_Y, conv_U, conv_V,
        output SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport master (
        output start, yuv_valid, Y_in, U_in, V_in,
        output conv_R, conv_G, conv_B,
        input  busy, done, yuv_ready, conv_enable,
        input  conv_Y, conv_U, conv_V,
        input  SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/rgb_write_scheduler.sv
// rgb_write_scheduler: feeds the 3-phase YUV->RGB converter, clips and packs
// pixel pairs into three SRAM words. Define RGB_CLIP_EN for 8-bit saturation.
module rgb_write_scheduler #(
    parameter logic [17:0] RGB_BASE = 18'd146944,
    parameter int          PIXELS   = 76800,
    parameter int          CONV_LAT = 3
) (
    input logic                  CLOCK_50_I,
    input logic                  reset,
    rgb_write_scheduler_if.slave bus
);

    localparam int             CW      = $clog2(PIXELS + 1);
    localparam logic [CW-1:0]  LP_NPIX = CW'(PIXELS);
    localparam logic [CW-1:0]  LP_LAST = CW'(PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [CW-1:0]       r_cnt;
    logic                r_par;
    logic                r_act;
    logic [1:0]          r_phase;
    logic [7:0]          r_y;
    logic [7:0]          r_u;
    logic [7:0]          r_v;
    logic [CONV_LAT-1:0] r_sh;
    logic [CONV_LAT-1:0] r_odd_sh;
    logic [7:0]          r_b0;
    logic [15:0]         r_w2;
    logic                r_w2_pend;
    logic                r_w2_out;
    logic [17:0]         r_next;
    logic [17:0]         r_addr;
    logic [15:0]         r_data;
    logic                r_we_n;

    logic                w_ready;
    logic                w_acc;
    logic                w_start;
    logic                w_samp;
    logic                w_samp_odd;
    logic [7:0]          w_r8;
    logic [7:0]          w_g8;
    logic [7:0]          w_b8;
    logic                w_unused_acc;

    assign w_ready = (r_state == S_RUN)
                   && (!r_act || r_phase == 2'd2)
                   && (r_cnt < LP_NPIX);
    assign w_acc      = bus.yuv_valid && w_ready;
    assign w_start    = (r_state == S_IDLE) && bus.start;
    assign w_samp     = r_sh[CONV_LAT-1];
    assign w_samp_odd = r_odd_sh[CONV_LAT-1];

`ifdef RGB_CLIP_EN
    assign w_r8 = bus.conv_R[31] ? 8'd0
                : (|bus.conv_R[30:24]) ? 8'hFF : bus.conv_R[23:16];
    assign w_g8 = bus.conv_G[31] ? 8'd0
                : (|bus.conv_G[30:24]) ? 8'hFF : bus.conv_G[23:16];
    assign w_b8 = bus.conv_B[31] ? 8'd0
                : (|bus.conv_B[30:24]) ? 8'hFF : bus.conv_B[23:16];
    assign w_unused_acc = ^{bus.conv_R[15:0], bus.conv_G[15:0],
                            bus.conv_B[15:0]};
`else
    assign w_r8 = bus.conv_R[23:16];
    assign w_g8 = bus.conv_G[23:16];
    assign w_b8 = bus.conv_B[23:16];
    assign w_unused_acc = ^{bus.conv_R[31:24], bus.conv_R[15:0],
                            bus.conv_G[31:24], bus.conv_G[15:0],
                            bus.conv_B[31:24], bus.conv_B[15:0]};
`endif

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.yuv_ready       = w_ready;
    assign bus.conv_enable     = r_act;
    assign bus.conv_Y          = {24'd0, r_y};
    assign bus.conv_U          = {24'd0, r_u};
    assign bus.conv_V          = {24'd0, r_v};
    assign bus.SRAM_address    = r_addr;
    assign bus.SRAM_write_data = r_data;
    assign bus.SRAM_we_n       = r_we_n;

    // Frame state machine with registered busy/done.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_acc && r_cnt == LP_LAST) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // only the last pair's word2 can be on the port here
                    if (r_w2_out) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pixel intake, converter phase counter and sample-time delay line.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_cnt    <= '0;
            r_par    <= 1'b0;
            r_act    <= 1'b0;
            r_phase  <= 2'd0;
            r_y      <= 8'd0;
            r_u      <= 8'd0;
            r_v      <= 8'd0;
            r_sh     <= '0;
            r_odd_sh <= '0;
        end else begin
            r_sh     <= (r_sh << 1) | CONV_LAT'(w_acc);
            r_odd_sh <= (r_odd_sh << 1) | CONV_LAT'(w_acc & r_par);
            if (w_start) begin
                r_cnt <= '0;
                r_par <= 1'b0;
            end
            if (w_acc) begin
                r_y     <= bus.Y_in;
                r_u     <= bus.U_in;
                r_v     <= bus.V_in;
                r_cnt   <= r_cnt + CW'(1);
                r_par   <= ~r_par;
                r_act   <= 1'b1;
                r_phase <= 2'd0;
            end else if (r_act) begin
                if (r_phase == 2'd2) begin
                    r_act <= 1'b0;
                end else begin
                    r_phase <= r_phase + 2'd1;
                end
            end
        end
    end

    // Result capture, pair packing and the SRAM write port.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_addr    <= 18'd0;
            r_data    <= 16'd0;
            r_we_n    <= 1'b1;
            r_next    <= 18'd0;
            r_b0      <= 8'd0;
            r_w2      <= 16'd0;
            r_w2_pend <= 1'b0;
            r_w2_out  <= 1'b0;
        end else begin
            r_we_n    <= 1'b1;
            r_w2_pend <= 1'b0;
            r_w2_out  <= 1'b0;
            if (w_start) begin
                r_next <= RGB_BASE;
            end
            if (w_samp) begin
                r_addr <= r_next;
                r_next <= r_next + 18'd1;
                r_we_n <= 1'b0;
                if (w_samp_odd) begin
                    r_data    <= {r_b0, w_r8};
                    r_w2      <= {w_g8, w_b8};
                    r_w2_pend <= 1'b1;
                end else begin
                    r_data <= {w_r8, w_g8};
                    r_b0   <= w_b8;
                end
            end else if (r_w2_pend) begin
                r_addr   <= r_next;
                r_next   <= r_next + 18'd1;
                r_data   <= r_w2;
                r_we_n   <= 1'b0;
                r_w2_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_write_scheduler.sv
// tb_rgb_write_scheduler: randomized scenarios checked against a pair-level
// model of clipping, packing, addressing and write timing.
module tb_rgb_write_scheduler;

    localparam logic [17:0] BASE = 18'd146944;
    localparam int          NPIX = 4;
    localparam int          LAT  = 3;

    typedef struct {
        int         cyc;
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } px_t;

    typedef struct {
        int          cyc;
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_n = 0;
    int   conv_mode = 0;
    px_t  acc_q[$];
    wr_t  wr_q[$];
    wr_t  exp_q[$];
    bit   en_q[$];

    rgb_write_scheduler_if bus();

    rgb_write_scheduler #(
        .RGB_BASE(BASE),
        .PIXELS  (NPIX),
        .CONV_LAT(LAT)
    ) dut (
        .CLOCK_50_I(clk),
        .reset     (rst),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] top8(logic [7:0] x);
        case (x[1:0])
            2'd0:    return 8'h00;
            2'd1:    return 8'hFF;
            default: return x;
        endcase
    endfunction

    // Converter model: accumulator as a function of the loaded pixel
    function automatic logic [31:0] acc_of(int mode, int ch,
                                           logic [7:0] y, logic [7:0] u,
                                           logic [7:0] v);
        if (mode == 1) return 32'h00FF_0000;
        if (mode == 2) begin
            if (ch == 0) return 32'(-5 * 65536);
            if (ch == 1) return 32'h0123_0000;
            return 32'h0080_0000;
        end
        if (ch == 0) return {top8(u), y, v, u};
        if (ch == 1) return {top8(v), u, y, v};
        return {top8(y), v, u, y};
    endfunction

    function automatic logic [7:0] clip8(logic [31:0] a);
        int s = $signed(a);
`ifdef RGB_CLIP_EN
        if (s < 0) return 8'd0;
        if (s >= 32'sh0100_0000) return 8'd255;
`endif
        return a[23:16];
    endfunction

    function automatic logic [7:0] chan(px_t p, int ch);
        return clip8(acc_of(conv_mode, ch, p.y, p.u, p.v));
    endfunction

    // Expected write list for the pixels accepted in the current frame
    function automatic void build_exp();
        exp_q.delete();
        for (int k = 0; k + 1 < acc_q.size(); k += 2) begin
            px_t         a  = acc_q[k];
            px_t         b  = acc_q[k+1];
            logic [17:0] ad = BASE + 18'(3 * (k / 2));
            exp_q.push_back('{a.cyc + LAT + 1, ad,
                              {chan(a, 0), chan(a, 1)}});
            exp_q.push_back('{b.cyc + LAT + 1, ad + 18'd1,
                              {chan(a, 2), chan(b, 0)}});
            exp_q.push_back('{b.cyc + LAT + 2, ad + 18'd2,
                              {chan(b, 1), chan(b, 2)}});
        end
    endfunction

    always_comb begin
        bus.conv_R = acc_of(conv_mode, 0, bus.conv_Y[7:0],
                            bus.conv_U[7:0], bus.conv_V[7:0]);
        bus.conv_G = acc_of(conv_mode, 1, bus.conv_Y[7:0],
                            bus.conv_U[7:0], bus.conv_V[7:0]);
        bus.conv_B = acc_of(conv_mode, 2, bus.conv_Y[7:0],
                            bus.conv_U[7:0], bus.conv_V[7:0]);
    end

    // Observation log, one entry per cycle at the falling edge
    initial forever begin
        @(negedge clk);
        en_q.push_back(bus.conv_enable);
        if (!rst && bus.yuv_valid && bus.yuv_ready)
            acc_q.push_back('{cyc, bus.Y_in, bus.U_in, bus.V_in});
        if (!bus.SRAM_we_n)
            wr_q.push_back('{cyc, bus.SRAM_address, bus.SRAM_write_data});
        if (bus.done) done_n++;
        cyc++;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        acc_q.delete();
        wr_q.delete();
        done_n = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.yuv_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        clear_log();
    endtask

    // Present a pixel and return just after the edge that accepts it
    task automatic send(logic [7:0] y, logic [7:0] u, logic [7:0] v);
        int t = 0;
        bus.Y_in = y;
        bus.U_in = u;
        bus.V_in = v;
        bus.yuv_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.yuv_ready) break;
            t++;
            if (t > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: ready=%b after %0d cycles, want 1",
                         bus.yuv_ready, t);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        send(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_reset();
        do_reset();
        tick(10);
        @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.done, bus.yuv_ready, bus.conv_enable} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, want 0000",
                     {bus.busy, bus.done, bus.yuv_ready, bus.conv_enable});
        end
        n_chk++;
        if ({bus.conv_Y, bus.conv_U, bus.conv_V} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_conv: got %h %h %h, want 0",
                     bus.conv_Y, bus.conv_U, bus.conv_V);
        end
        n_chk++;
        if ({bus.SRAM_address, bus.SRAM_write_data} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_sram: got a=%h d=%h, want 0",
                     bus.SRAM_address, bus.SRAM_write_data);
        end
        n_chk++;
        if (bus.SRAM_we_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_we_n: got %b, want 1", bus.SRAM_we_n);
        end
        rst = 1'b1;
        bus.start = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.start = 1'b0;
        tick(2);
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_reset: busy=%b, want 0", bus.busy);
        end
        tick(1);
        start_frame();
        tick(5);
        @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.yuv_ready, bus.conv_enable} !== 3'b110) begin
            n_fail++;
            $display("FAIL start_idle_src: busy/ready/en=%b, want 110",
                     {bus.busy, bus.yuv_ready, bus.conv_enable});
        end
        n_chk++;
        if (wr_q.size() !== 0) begin
            n_fail++;
            $display("FAIL start_no_writes: got %0d writes, want 0",
                     wr_q.size());
        end
    endtask

    task automatic test_white();
        do_reset();
        conv_mode = 1;
        start_frame();
        for (int i = 0; i < NPIX; i++) begin
            send(8'd235, 8'd128, 8'd128);
            bus.yuv_valid = 1'b0;
            tick(2);
        end
        tick(12);
        build_exp();
        n_chk++;
        if (wr_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL white_count: got %0d, want %0d",
                     wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (wr_q[i].addr !== exp_q[i].addr ||
                wr_q[i].data !== 16'hFFFF ||
                wr_q[i].cyc !== exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL white_w%0d: got a=%h d=%h c=%0d, want a=%h d=ffff c=%0d",
                         i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc,
                         exp_q[i].addr, exp_q[i].cyc);
            end
        end
        if (wr_q.size() > 0 && acc_q.size() > 0) begin
            n_chk++;
            if (wr_q[0].cyc - acc_q[0].cyc !== LAT + 1) begin
                n_fail++;
                $display("FAIL white_latency: got %0d, want %0d",
                         wr_q[0].cyc - acc_q[0].cyc, LAT + 1);
            end
        end
        @(negedge clk);
        n_chk++;
        if (done_n !== 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL white_done: got done=%0d busy=%b, want 1 0",
                     done_n, bus.busy);
        end
    endtask

    task automatic test_clip();
        logic [15:0] w[3];
`ifdef RGB_CLIP_EN
        w = '{16'h00FF, 16'h8000, 16'hFF80};
`else
        w = '{16'hFB23, 16'h80FB, 16'h2380};
`endif
        do_reset();
        conv_mode = 2;
        start_frame();
        for (int i = 0; i < NPIX; i++) begin
            send_rand();
            bus.yuv_valid = 1'b0;
            tick(1);
        end
        tick(12);
        n_chk++;
        if (wr_q.size() !== 3 * NPIX / 2) begin
            n_fail++;
            $display("FAIL clip_count: got %0d, want %0d",
                     wr_q.size(), 3 * NPIX / 2);
        end
        for (int i = 0; i < wr_q.size() && i < 3 * NPIX / 2; i++) begin
            n_chk++;
            if (wr_q[i].data !== w[i % 3] ||
                wr_q[i].addr !== BASE + 18'(i)) begin
                n_fail++;
                $display("FAIL clip_w%0d: got a=%h d=%h, want a=%h d=%h",
                         i, wr_q[i].addr, wr_q[i].data,
                         BASE + 18'(i), w[i % 3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        int a0;
        int al;
        do_reset();
        conv_mode = 0;
        start_frame();
        for (int i = 0; i < NPIX; i++) send_rand();
        tick(12);
        bus.yuv_valid = 1'b0;
        n_chk++;
        if (acc_q.size() !== NPIX) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d, want %0d",
                     acc_q.size(), NPIX);
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            n_chk++;
            if (acc_q[i].cyc - acc_q[i-1].cyc !== 3) begin
                n_fail++;
                $display("FAIL b2b_spacing%0d: got %0d, want 3",
                         i, acc_q[i].cyc - acc_q[i-1].cyc);
            end
        end
        if (acc_q.size() > 0) begin
            a0 = acc_q[0].cyc;
            al = acc_q[acc_q.size()-1].cyc;
            for (int c = a0 + 1; c <= al + 3; c++)
                if (!en_q[c]) gaps++;
            n_chk++;
            if (gaps !== 0 || en_q[al+4] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_enable: got gaps=%0d tail=%b, want 0 0",
                         gaps, en_q[al+4]);
            end
        end
        build_exp();
        n_chk++;
        if (wr_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, want %0d",
                     wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (wr_q[i].addr !== exp_q[i].addr ||
                wr_q[i].data !== exp_q[i].data ||
                wr_q[i].cyc !== exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL b2b_w%0d: got a=%h d=%h c=%0d, want a=%h d=%h c=%0d",
                         i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        n_chk++;
        if (done_n !== 1) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d pulses, want 1", done_n);
        end
    endtask

    task automatic test_stall();
        do_reset();
        conv_mode = 0;
        start_frame();
        send_rand();
        bus.yuv_valid = 1'b0;
        tick(10);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(9);
        n_chk++;
        if (wr_q.size() !== 1) begin
            n_fail++;
            $display("FAIL stall_writes: got %0d during stall, want 1",
                     wr_q.size());
        end
        for (int i = 1; i < NPIX; i++) begin
            send_rand();
            bus.yuv_valid = 1'b0;
            tick(1);
        end
        tick(12);
        build_exp();
        n_chk++;
        if (wr_q.size() !== 6 || exp_q.size() !== 6) begin
            n_fail++;
            $display("FAIL stall_count: got %0d, want 6 (model %0d)",
                     wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (wr_q[i].addr !== exp_q[i].addr ||
                wr_q[i].data !== exp_q[i].data ||
                wr_q[i].cyc !== exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL stall_w%0d: got a=%h d=%h c=%0d, want a=%h d=%h c=%0d",
                         i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        n_chk++;
        if (done_n !== 1) begin
            n_fail++;
            $display("FAIL stall_done: got %0d pulses, want 1", done_n);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        conv_mode = 0;
        start_frame();
        send_rand();
        send_rand();
        rst = 1'b1;
        bus.yuv_valid = 1'b0;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || bus.SRAM_we_n !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_idle: got busy=%b we_n=%b, want 0 1",
                     bus.busy, bus.SRAM_we_n);
        end
        tick(10);
        n_chk++;
        if (wr_q.size() !== 1 || done_n !== 0) begin
            n_fail++;
            $display("FAIL midrst_writes: got %0d writes %0d done, want 1 0",
                     wr_q.size(), done_n);
        end
        start_frame();
        for (int i = 0; i < NPIX; i++) send_rand();
        bus.yuv_valid = 1'b0;
        tick(12);
        build_exp();
        n_chk++;
        if (wr_q.size() !== exp_q.size() || wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d, want %0d",
                     wr_q.size(), exp_q.size());
        end else if (wr_q[0].addr !== BASE) begin
            n_fail++;
            $display("FAIL midrst_base: got %h, want %h", wr_q[0].addr, BASE);
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (wr_q[i].addr !== exp_q[i].addr ||
                wr_q[i].data !== exp_q[i].data ||
                wr_q[i].cyc !== exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL midrst_w%0d: got a=%h d=%h c=%0d, want a=%h d=%h c=%0d",
                         i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_random_frames();
        int gap;
        do_reset();
        conv_mode = 0;
        for (int f = 0; f < 4; f++) begin
            start_frame();
            for (int i = 0; i < NPIX; i++) begin
                send_rand();
                gap = $urandom_range(0, 4);
                if (gap > 0) begin
                    bus.yuv_valid = 1'b0;
                    tick(gap);
                end
            end
            bus.yuv_valid = 1'b0;
            tick(14);
            build_exp();
            n_chk++;
            if (wr_q.size() !== exp_q.size() || done_n !== 1) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d writes %0d done, want %0d 1",
                         f, wr_q.size(), done_n, exp_q.size());
            end
            for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
                n_chk++;
                if (wr_q[i].addr !== exp_q[i].addr ||
                    wr_q[i].data !== exp_q[i].data ||
                    wr_q[i].cyc !== exp_q[i].cyc) begin
                    n_fail++;
                    $display("FAIL rand%0d_w%0d: got a=%h d=%h c=%0d, want a=%h d=%h c=%0d",
                             f, i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc,
                             exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.yuv_valid = 1'b0;
        bus.Y_in = 8'd0;
        bus.U_in = 8'd0;
        bus.V_in = 8'd0;
        rst = 1'b1;
        tick(1);
        test_reset();
        test_white();
        test_clip();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_write_scheduler.md
# rgb_write_scheduler

Sequences the 3-phase YUV→RGB converter datapath for the colourspace-conversion stage: accepts one upsampled YUV pixel at a time from the upsampling stage, drives the converter inputs and enable, and captures its 32-bit accumulator outputs at a fixed latency. It clips each accumulator to 8 bits, packs pixel pairs into three 16-bit SRAM words, and writes them sequentially into the RGB segment. The block sits between the U/V upsampler and the SRAM write port, and owns that port while busy.

## Interface
- RGB_BASE, 18'd146944: SRAM word address of the first RGB word.
- PIXELS, 76800: pixels per frame; must be even.
- CONV_LAT, 3: cycles from converter input load to valid accumulator outputs.
- CLOCK_50_I in 1: 50 MHz clock; the only clock.
- reset in 1: synchronous, active-high reset.
- start in 1: one-cycle pulse that begins a frame; ignored unless the block is in IDLE.
- busy out 1: high in every state except IDLE.
- done out 1: one-cycle pulse after the frame's last SRAM write.
- yuv_valid in 1: source holds a pixel on Y_in/U_in/V_in.
- yuv_ready out 1: block can accept a pixel this cycle.
- Y_in, U_in, V_in in 8 each: unsigned pixel components.
- conv_enable out 1: runs the converter's phase counter.
- conv_Y, conv_U, conv_V out 32 each: zero-extended registered components.
- conv_R, conv_G, conv_B in 32 each, signed: converter accumulator results, 16.16 fixed point.
- SRAM_address out 18: write address.
- SRAM_write_data out 16: write data.
- SRAM_we_n out 1: active-low write enable.

## Operation
- FSM states:
  - IDLE → RUN on start.
  - RUN → DRAIN when pixel PIXELS-1 is accepted.
  - DRAIN → DONE after the final word2 write.
  - DONE → IDLE after one cycle, with done=1 in that cycle.
- Accept: a pixel is accepted at any edge where yuv_valid && yuv_ready. Its components load into conv_Y/U/V, and a 2-bit phase counter goes 0,1,2.
- yuv_ready = 1 only in RUN, with phase counter idle or equal to 2, and accepted count < PIXELS. Maximum rate is one pixel per 3 cycles.
- conv_enable is high exactly during the 3 phase cycles of an accepted pixel. Otherwise it is 0 and conv_Y/U/V hold their values.
- Clip, applied per channel to acc:
  - acc < 0 → 8'd0.
  - acc[31:24] != 0 → 8'd255.
  - else acc[23:16].
- Packing, for pixel pair (even pixel 0, odd pixel 1):
  - word0 = {R0,G0} written at RGB_BASE+3k.
  - word1 = {B0,R1}.
  - word2 = {G1,B1}.
  - k is the pair index. The address increments by 1 per write.
- B0 is held in an internal register until pixel 1 completes. A source stall mid-pair holds B0 indefinitely; no write is issued.
- No SRAM write occurs except the three words of each pair. Total writes per frame = 3·PIXELS/2.

## Timing
- Reset values:
  - All-zero outputs: busy, done, yuv_ready, conv_enable, conv_Y/U/V, SRAM_address, SRAM_write_data.
  - SRAM_we_n=1.
  - State IDLE; pixel count, pair index and B0 cleared.
- Reset mid-frame: returns to IDLE next edge. Partial pairs are discarded; done is not pulsed.
- Phase 0 is the cycle after the accept edge E. conv_R/G/B are sampled at edge E+CONV_LAT.
- Even pixel: word0 is driven with SRAM_we_n=0 in the cycle after the sample edge.
- Odd pixel: word1 is driven in the cycle after the sample edge, word2 in the following cycle.
- Back-to-back pixels never collide on the write port; word2 completes before the next sample edge.
- start coincident with reset: reset wins. start during busy: no effect.
- done pulses the cycle after word2 of the last pair. busy falls the cycle after done.

## Configuration
- RGB_CLIP_EN defined: clip rule as above.
- RGB_CLIP_EN undefined: each channel = acc[23:16] with no saturation, matching raw truncation; wraps on overflow or underflow.

## Test plan
- Reset, then idle 10 cycles → all outputs at reset values; start with yuv_valid=0 → busy=1, no writes, yuv_ready=1.
- Pixel pair Y=235,U=128,V=128 twice, with converter model accumulators 0x00FF_0000 → words 0xFFFF,0xFFFF,0xFFFF at RGB_BASE..+2; first write CONV_LAT+1 cycles after accept.
- Converter model returns R=-5·65536, G=0x0123_0000, B=0x0080_0000 → with RGB_CLIP_EN R=0x00, G=0xFF, B=0x80; without it R=0xFB, G=0x23, B=0x80.
- yuv_valid held high continuously → accepts exactly every 3 cycles; conv_enable never low between pixels; no overlapping SRAM_we_n pulses.
- PIXELS=4, source stalls 20 cycles after pixel 0 → word0 written once, no further writes during stall; after resume, word1={B0,R1} is correct, done pulses once, and 6 total writes occur.
- reset asserted in the cycle after pixel 1 is accepted → IDLE next edge, SRAM_we_n=1, no word1/word2 written; a new start rewrites from RGB_BASE.
